// File: rtl/bsg_serial_in_parallel_out_assembler_if.sv
// rtl/bsg_serial_in_parallel_out_assembler_if.sv - serial element in / assembled word out handshake bundle
// slave is the assembler side, master is its environment (serializer upstream, consumer downstream).
interface bsg_serial_in_parallel_out_assembler_if #(
    parameter int width_p = 16,
    parameter int els_p   = 4
);
    logic                          valid_i;
    logic [width_p-1:0]            data_i;
    logic                          yumi_o;
    logic                          valid_o;
    logic [els_p-1:0][width_p-1:0] data_o;
    logic                          yumi_i;

    modport slave  (input  valid_i, data_i, yumi_i, output yumi_o, valid_o, data_o);
    modport master (output valid_i, data_i, yumi_i, input  yumi_o, valid_o, data_o);
endinterface

// File: rtl/bsg_serial_in_parallel_out_assembler.sv
// rtl/bsg_serial_in_parallel_out_assembler.sv - reassembles els_p serial elements into one parallel word
// Optional macro BSG_SIPO_ASSEMBLER_SKID_EN adds an output register so word N+1 fills while word N waits.
module bsg_serial_in_parallel_out_assembler #(
    parameter int width_p    = 16,
    parameter int els_p      = 4,
    parameter int hi_to_lo_p = 0
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_serial_in_parallel_out_assembler_if.slave io
);
    localparam int ctr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ctr_w_lp-1:0] ctr_last_lp = ctr_w_lp'(els_p - 1);

    logic [ctr_w_lp-1:0]           r_ctr;
    logic [ctr_w_lp-1:0]           w_idx;
    logic [els_p-1:0][width_p-1:0] r_asm;
    logic [els_p-1:0][width_p-1:0] w_asm_next;
    logic                          w_accept_ok;
    logic                          w_accept;
    logic                          w_last;
    logic                          w_yumi_out;

    assign w_idx      = (hi_to_lo_p != 0) ? (ctr_last_lp - r_ctr) : r_ctr;
    assign w_accept   = io.valid_i & w_accept_ok & ~reset_i;
    assign w_last     = (r_ctr == ctr_last_lp);
    assign w_yumi_out = io.yumi_i & io.valid_o;
    assign io.yumi_o  = w_accept;

    // Assembly buffer with the incoming element merged in, used both to update
    // the buffer and to load a complete word straight into the output register.
    always_comb begin
        w_asm_next        = r_asm;
        w_asm_next[w_idx] = io.data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ctr <= '0;
        end else if (w_accept) begin
            r_ctr <= w_last ? '0 : r_ctr + 1'b1;
        end
    end

`ifdef BSG_SIPO_ASSEMBLER_SKID_EN
    logic [els_p-1:0][width_p-1:0] r_out;
    logic                          r_out_v;
    logic                          r_asm_full;

    assign w_accept_ok = ~r_asm_full;
    assign io.valid_o  = r_out_v;
    assign io.data_o   = r_out;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_asm      <= '0;
            r_out      <= '0;
            r_out_v    <= 1'b0;
            r_asm_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm <= w_asm_next;
            end
            if (w_accept && w_last) begin
                if (!r_out_v || w_yumi_out) begin
                    r_out   <= w_asm_next;
                    r_out_v <= 1'b1;
                end else begin
                    r_asm_full <= 1'b1;
                end
            end else if (r_asm_full && w_yumi_out) begin
                // Parked word moves up; the output stays valid.
                r_out      <= r_asm;
                r_asm_full <= 1'b0;
            end else if (w_yumi_out) begin
                r_out_v <= 1'b0;
            end
        end
    end
`else
    typedef enum logic {s_fill, s_full} state_e;

    state_e r_state;
    state_e w_state_next;
    logic   w_valid;

    assign io.valid_o = w_valid;
    assign io.data_o  = r_asm;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= s_fill;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept_ok  = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            s_fill: begin
                w_accept_ok = 1'b1;
                if (io.valid_i && w_last) begin
                    w_state_next = s_full;
                end
            end
            s_full: begin
                w_valid = 1'b1;
                if (w_yumi_out) begin
                    w_state_next = s_fill;
                end
            end
            default: w_state_next = s_fill;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_asm <= '0;
        end else if (w_accept) begin
            r_asm <= w_asm_next;
        end
    end
`endif

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) io.yumi_i |-> io.valid_o);

endmodule
